if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 154 +++++++++++++++
 tb/tb_if_stage.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage. Takes one entry at a time from pre-IF, waits for
// the ICache to return the instruction word (unless the entry carries an
// exception or no instruction), and hands the completed entry to decode.
// A flush while a response is still owed moves to DROP so that the stale
// word is swallowed instead of being paired with a younger entry.
module if_stage #(
  parameter int PS_TO_FS_BUS_WD = 40,
  parameter int FS_TO_DS_BUS_WD = 71
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ps_to_fs_valid,
  input  logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
  output logic                       fs_allowin,
  input  logic                       icache_data_ok,
  input  logic [31:0]                icache_rdata,
  input  logic                       ds_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic                       flush
);

  // Field positions inside the incoming pre-IF bus.
  localparam int PS_INST_VALID = 39;
  localparam int PS_BDD        = 38;
  localparam int PS_PC_HI      = 37;
  localparam int PS_PC_LO      = 6;
  localparam int PS_EX         = 5;
  localparam int PS_EXCTYPE_HI = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Held entry fields; these are the only source of the outgoing bus.
  logic        bdd_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic        ex_r;
  logic [4:0]  exctype_r;

  // Decoded view of the offered pre-IF entry.
  logic        in_inst_valid;
  logic        in_bdd;
  logic [31:0] in_pc;
  logic        in_ex;
  logic [4:0]  in_exctype;
  logic        in_needs_fetch;

  logic accept;
  logic capture;

  // Split the pre-IF bus into its named fields.
  always_comb begin
    in_inst_valid  = ps_to_fs_bus[PS_INST_VALID];
    in_bdd         = ps_to_fs_bus[PS_BDD];
    in_pc          = ps_to_fs_bus[PS_PC_HI:PS_PC_LO];
    in_ex          = ps_to_fs_bus[PS_EX];
    in_exctype     = ps_to_fs_bus[PS_EXCTYPE_HI:0];
    in_needs_fetch = in_inst_valid & ~in_ex;
  end

  // Handshake towards pre-IF: room exists when empty, or when the held
  // entry leaves for decode this same cycle. Flush blocks acceptance.
  always_comb begin
    fs_allowin = (state == ST_EMPTY) | ((state == ST_FULL) & ds_allowin);
    accept     = ps_to_fs_valid & fs_allowin & ~flush;
  end

  // Next-state logic; flush is examined first so it beats both acceptance
  // and the decode handshake. data_ok is only meaningful in WAIT and DROP.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (flush) begin
          state_next = ST_EMPTY;
        end else if (accept) begin
          state_next = in_needs_fetch ? ST_WAIT : ST_FULL;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_next = icache_data_ok ? ST_EMPTY : ST_DROP;
        end else if (icache_data_ok) begin
          state_next = ST_FULL;
          capture    = 1'b1;
        end
      end
      ST_FULL: begin
        if (flush) begin
          state_next = ST_EMPTY;
        end else if (ds_allowin) begin
          if (accept) begin
            state_next = in_needs_fetch ? ST_WAIT : ST_FULL;
          end else begin
            state_next = ST_EMPTY;
          end
        end
      end
      ST_DROP: begin
        if (icache_data_ok) begin
          state_next = ST_EMPTY;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Entry registers: load descriptor fields on acceptance (inst cleared so
  // exception/no-inst entries carry zero), then fill inst from the ICache.
  always_ff @(posedge clk) begin
    if (reset) begin
      bdd_r     <= 1'b0;
      pc_r      <= 32'h0;
      inst_r    <= 32'h0;
      ex_r      <= 1'b0;
      exctype_r <= 5'h0;
    end else if (accept) begin
      bdd_r     <= in_bdd;
      pc_r      <= in_pc;
      inst_r    <= 32'h0;
      ex_r      <= in_ex;
      exctype_r <= in_exctype;
    end else if (capture) begin
      inst_r    <= icache_rdata;
    end
  end

  // Outputs towards decode come straight from state and entry registers.
  always_comb begin
    fs_to_ds_valid = (state == ST_FULL);
    fs_to_ds_bus   = {bdd_r, pc_r, inst_r, ex_r, exctype_r};
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by a long
// randomized run compared against an occupancy-based reference model.
module tb_if_stage;

  localparam int PSW = 40;
  localparam int FSW = 71;
  localparam logic [4:0] ADEL = 5'h04;

  logic           clk = 1'b0;
  logic           reset;
  logic           ps_to_fs_valid;
  logic [PSW-1:0] ps_to_fs_bus;
  logic           fs_allowin;
  logic           icache_data_ok;
  logic [31:0]    icache_rdata;
  logic           ds_allowin;
  logic           fs_to_ds_valid;
  logic [FSW-1:0] fs_to_ds_bus;
  logic           flush;

  int check_cnt = 0;
  int pass_cnt  = 0;
  bit deadbeef_seen = 1'b0;

  always #5 clk = ~clk;

  if_stage #(.PS_TO_FS_BUS_WD(PSW), .FS_TO_DS_BUS_WD(FSW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ps_to_fs_valid(ps_to_fs_valid),
    .ps_to_fs_bus  (ps_to_fs_bus),
    .fs_allowin    (fs_allowin),
    .icache_data_ok(icache_data_ok),
    .icache_rdata  (icache_rdata),
    .ds_allowin    (ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus  (fs_to_ds_bus),
    .flush         (flush)
  );

  function automatic logic [PSW-1:0] mk_ps(input logic iv, input logic bdd,
                                           input logic [31:0] pc, input logic ex,
                                           input logic [4:0] et);
    return {iv, bdd, pc, ex, et};
  endfunction

  function automatic logic [FSW-1:0] mk_ds(input logic bdd, input logic [31:0] pc,
                                           input logic [31:0] inst, input logic ex,
                                           input logic [4:0] et);
    return {bdd, pc, inst, ex, et};
  endfunction

  // Watch for the stale word ever being presented to decode.
  always @(negedge clk) begin
    if (!reset && fs_to_ds_valid && fs_to_ds_bus[37:6] == 32'hDEADBEEF)
      deadbeef_seen = 1'b1;
  end

  // Protocol monitor: a response must only arrive while one is owed,
  // i.e. while the stage neither holds an entry nor accepts a new one.
  always @(posedge clk) begin
    if (!reset && icache_data_ok && (fs_to_ds_valid || fs_allowin)) begin
      check_cnt++;
      $display("[TB] FAIL data_ok_protocol: data_ok while valid=%0b allowin=%0b, required neither",
               fs_to_ds_valid, fs_allowin);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ps_to_fs_valid = 1'b0;
    ps_to_fs_bus   = '0;
    icache_data_ok = 1'b0;
    icache_rdata   = 32'h0;
    ds_allowin     = 1'b1;
    flush          = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(1'b1, 1'b1, 32'h1234_5678, 1'b0, 5'h0);
    icache_data_ok = 1'b1;
    icache_rdata   = 32'hFFFF_FFFF;
    flush          = 1'b1;
    ds_allowin     = 1'b0;
    tick();
    tick();
    check_cnt++;
    if (fs_to_ds_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b, want 0", fs_to_ds_valid);
    else pass_cnt++;
    check_cnt++;
    if (fs_allowin !== 1'b1) $display("[TB] FAIL reset_allowin: got %0b, want 1", fs_allowin);
    else pass_cnt++;
    check_cnt++;
    if (fs_to_ds_bus !== '0) $display("[TB] FAIL reset_bus: got %h, want 0", fs_to_ds_bus);
    else pass_cnt++;
    drive_idle();
    reset = 1'b0;
    tick();
    check_cnt++;
    if (fs_allowin !== 1'b1 || fs_to_ds_valid !== 1'b0)
      $display("[TB] FAIL post_reset_idle: allowin=%0b valid=%0b, want 1/0", fs_allowin, fs_to_ds_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic_fetch();
    int valid_cycles;
    drive_idle();
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 5'h0);
    tick();
    ps_to_fs_valid = 1'b0;
    #1;
    check_cnt++;
    if (fs_to_ds_valid !== 1'b0 || fs_allowin !== 1'b0)
      $display("[TB] FAIL basic_wait: valid=%0b allowin=%0b, want 0/0", fs_to_ds_valid, fs_allowin);
    else pass_cnt++;
    tick();
    icache_data_ok = 1'b1;
    icache_rdata   = 32'h2408_0001;
    tick();
    icache_data_ok = 1'b0;
    icache_rdata   = 32'h0;
    valid_cycles = fs_to_ds_valid ? 1 : 0;
    check_cnt++;
    if (fs_to_ds_bus !== mk_ds(1'b0, 32'hBFC0_0000, 32'h2408_0001, 1'b0, 5'h0))
      $display("[TB] FAIL basic_bus: got %h, want %h", fs_to_ds_bus,
               mk_ds(1'b0, 32'hBFC0_0000, 32'h2408_0001, 1'b0, 5'h0));
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (fs_to_ds_valid) valid_cycles++;
    end
    check_cnt++;
    if (valid_cycles !== 1) $display("[TB] FAIL basic_valid_cycles: got %0d, want 1", valid_cycles);
    else pass_cnt++;
    check_cnt++;
    if (fs_allowin !== 1'b1) $display("[TB] FAIL basic_back_empty: allowin=%0b, want 1", fs_allowin);
    else pass_cnt++;
  endtask

  task automatic test_exception_and_stall();
    logic [FSW-1:0] held;
    drive_idle();
    ds_allowin     = 1'b0;
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(1'b1, 1'b0, 32'hBFC0_0002, 1'b1, ADEL);
    tick();
    held = mk_ds(1'b0, 32'hBFC0_0002, 32'h0, 1'b1, ADEL);
    check_cnt++;
    if (fs_to_ds_valid !== 1'b1) $display("[TB] FAIL exc_valid: got %0b, want 1", fs_to_ds_valid);
    else pass_cnt++;
    check_cnt++;
    if (fs_to_ds_bus !== held) $display("[TB] FAIL exc_bus: got %h, want %h", fs_to_ds_bus, held);
    else pass_cnt++;
    ps_to_fs_bus = mk_ps(1'b0, 1'b1, 32'h8000_0010, 1'b0, 5'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_cnt++;
      if (fs_to_ds_bus !== held || fs_to_ds_valid !== 1'b1)
        $display("[TB] FAIL stall_hold[%0d]: bus=%h valid=%0b, want %h/1", i, fs_to_ds_bus, fs_to_ds_valid, held);
      else pass_cnt++;
      check_cnt++;
      if (fs_allowin !== 1'b0) $display("[TB] FAIL stall_allowin[%0d]: got %0b, want 0", i, fs_allowin);
      else pass_cnt++;
    end
    ds_allowin = 1'b1;
    #1;
    check_cnt++;
    if (fs_allowin !== 1'b1) $display("[TB] FAIL release_allowin: got %0b, want 1", fs_allowin);
    else pass_cnt++;
    tick();
    ps_to_fs_valid = 1'b0;
    check_cnt++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== mk_ds(1'b1, 32'h8000_0010, 32'h0, 1'b0, 5'h0))
      $display("[TB] FAIL full_to_full: valid=%0b bus=%h, want 1/%h", fs_to_ds_valid, fs_to_ds_bus,
               mk_ds(1'b1, 32'h8000_0010, 32'h0, 1'b0, 5'h0));
    else pass_cnt++;
    tick();
    check_cnt++;
    if (fs_to_ds_valid !== 1'b0) $display("[TB] FAIL drain_after_stall: valid=%0b, want 0", fs_to_ds_valid);
    else pass_cnt++;
  endtask

  task automatic test_flush_drop();
    drive_idle();
    deadbeef_seen  = 1'b0;
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(1'b1, 1'b0, 32'h8000_1000, 1'b0, 5'h0);
    tick();
    ps_to_fs_valid = 1'b0;
    flush          = 1'b1;
    tick();
    flush          = 1'b0;
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(1'b0, 1'b0, 32'h8000_2000, 1'b0, 5'h0);
    #1;
    check_cnt++;
    if (fs_allowin !== 1'b0 || fs_to_ds_valid !== 1'b0)
      $display("[TB] FAIL drop_entered: allowin=%0b valid=%0b, want 0/0", fs_allowin, fs_to_ds_valid);
    else pass_cnt++;
    tick();
    ps_to_fs_valid = 1'b0;
    flush          = 1'b1;
    tick();
    flush = 1'b0;
    check_cnt++;
    if (fs_allowin !== 1'b0 || fs_to_ds_valid !== 1'b0)
      $display("[TB] FAIL drop_second_flush: allowin=%0b valid=%0b, want 0/0", fs_allowin, fs_to_ds_valid);
    else pass_cnt++;
    icache_data_ok = 1'b1;
    icache_rdata   = 32'hDEAD_BEEF;
    tick();
    icache_data_ok = 1'b0;
    icache_rdata   = 32'h0;
    check_cnt++;
    if (fs_allowin !== 1'b1 || fs_to_ds_valid !== 1'b0)
      $display("[TB] FAIL drop_to_empty: allowin=%0b valid=%0b, want 1/0", fs_allowin, fs_to_ds_valid);
    else pass_cnt++;
    tick();
    tick();
    check_cnt++;
    if (deadbeef_seen !== 1'b0) $display("[TB] FAIL stale_word_leak: seen=%0b, want 0", deadbeef_seen);
    else pass_cnt++;
  endtask

  task automatic test_flush_with_data_ok();
    drive_idle();
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(1'b1, 1'b1, 32'h8000_3000, 1'b0, 5'h0);
    tick();
    ps_to_fs_valid = 1'b0;
    flush          = 1'b1;
    icache_data_ok = 1'b1;
    icache_rdata   = 32'h1234_5678;
    tick();
    drive_idle();
    check_cnt++;
    if (fs_allowin !== 1'b1 || fs_to_ds_valid !== 1'b0)
      $display("[TB] FAIL flush_wait_dataok: allowin=%0b valid=%0b, want 1/0", fs_allowin, fs_to_ds_valid);
    else pass_cnt++;
  endtask

  task automatic test_flush_priority();
    drive_idle();
    ds_allowin     = 1'b0;
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(1'b0, 1'b0, 32'h8000_4000, 1'b0, 5'h0);
    tick();
    flush        = 1'b1;
    ds_allowin   = 1'b1;
    ps_to_fs_bus = mk_ps(1'b0, 1'b1, 32'h8000_4004, 1'b0, 5'h0);
    tick();
    check_cnt++;
    if (fs_to_ds_valid !== 1'b0 || fs_allowin !== 1'b1)
      $display("[TB] FAIL flush_full_priority: valid=%0b allowin=%0b, want 0/1", fs_to_ds_valid, fs_allowin);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (fs_to_ds_valid !== 1'b0)
      $display("[TB] FAIL flush_empty_priority: valid=%0b, want 0", fs_to_ds_valid);
    else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0]    pcs[8];
    logic [31:0]    insts[8];
    logic [FSW-1:0] seen[$];
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      pcs[i]   = 32'h8000_8000 + 32'(i * 4);
      insts[i] = $urandom;
    end
    for (int i = 0; i < 8; i++) begin
      ps_to_fs_valid = 1'b1;
      ps_to_fs_bus   = mk_ps(1'b1, 1'b0, pcs[i], 1'b0, 5'h0);
      icache_data_ok = 1'b0;
      tick();
      if (fs_to_ds_valid) seen.push_back(fs_to_ds_bus);
      ps_to_fs_valid = 1'b0;
      icache_data_ok = 1'b1;
      icache_rdata   = insts[i];
      tick();
      icache_data_ok = 1'b0;
      if (fs_to_ds_valid) seen.push_back(fs_to_ds_bus);
    end
    tick();
    if (fs_to_ds_valid) seen.push_back(fs_to_ds_bus);
    check_cnt++;
    if (seen.size() !== 8) $display("[TB] FAIL b2b_count: got %0d, want 8", seen.size());
    else pass_cnt++;
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      check_cnt++;
      if (seen[i] !== mk_ds(1'b0, pcs[i], insts[i], 1'b0, 5'h0))
        $display("[TB] FAIL b2b_entry[%0d]: got %h, want %h", i, seen[i],
                 mk_ds(1'b0, pcs[i], insts[i], 1'b0, 5'h0));
      else pass_cnt++;
    end
    drive_idle();
  endtask

  task automatic test_reset_in_wait();
    drive_idle();
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(1'b1, 1'b1, 32'h8000_5000, 1'b0, 5'h3);
    tick();
    ps_to_fs_valid = 1'b0;
    reset          = 1'b1;
    tick();
    check_cnt++;
    if (fs_to_ds_valid !== 1'b0 || fs_allowin !== 1'b1 || fs_to_ds_bus !== '0)
      $display("[TB] FAIL reset_in_wait: valid=%0b allowin=%0b bus=%h, want 0/1/0",
               fs_to_ds_valid, fs_allowin, fs_to_ds_bus);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    check_cnt++;
    if (fs_allowin !== 1'b1) $display("[TB] FAIL after_reset_in_wait: allowin=%0b, want 1", fs_allowin);
    else pass_cnt++;
  endtask

  // Reference model: the stage either holds a finished entry, has one
  // waiting on the ICache, owes a response for a flushed entry, or is idle.
  task automatic test_random();
    bit             m_hold = 1'b0;
    bit             m_pend = 1'b0;
    bit             m_owed = 1'b0;
    logic [FSW-1:0] m_hold_bus = '0;
    logic           p_bdd = 1'b0;
    logic [31:0]    p_pc = 32'h0;
    logic [4:0]     p_et = 5'h0;
    logic           exp_allow;
    logic           iv, bdd, ex, acc;
    logic [31:0]    pc;
    logic [4:0]     et;
    drive_idle();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      iv  = ($urandom_range(0, 3) != 0);
      ex  = ($urandom_range(0, 3) == 0);
      bdd = 1'($urandom_range(0, 1));
      pc  = $urandom;
      et  = 5'($urandom_range(0, 31));
      ps_to_fs_valid = 1'($urandom_range(0, 1));
      ps_to_fs_bus   = mk_ps(iv, bdd, pc, ex, et);
      ds_allowin     = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 9) == 0);
      icache_data_ok = (m_pend || m_owed) ? 1'($urandom_range(0, 1)) : 1'b0;
      icache_rdata   = $urandom;
      #1;
      exp_allow = !m_pend && !m_owed && (!m_hold || ds_allowin);
      check_cnt++;
      if (fs_allowin !== exp_allow)
        $display("[TB] FAIL rand_allowin@%0d: got %0b, want %0b", cyc, fs_allowin, exp_allow);
      else pass_cnt++;
      acc = ps_to_fs_valid && exp_allow && !flush;
      if (flush) begin
        if (m_pend) m_owed = !icache_data_ok;
        else if (m_owed && icache_data_ok) m_owed = 1'b0;
        m_pend = 1'b0;
        m_hold = 1'b0;
      end else begin
        if (m_owed && icache_data_ok) begin
          m_owed = 1'b0;
        end else if (m_pend && icache_data_ok) begin
          m_pend     = 1'b0;
          m_hold     = 1'b1;
          m_hold_bus = mk_ds(p_bdd, p_pc, icache_rdata, 1'b0, p_et);
        end else if (m_hold && ds_allowin) begin
          m_hold = 1'b0;
        end
        if (acc) begin
          m_hold = 1'b0;
          if (iv && !ex) begin
            m_pend = 1'b1;
            p_bdd  = bdd;
            p_pc   = pc;
            p_et   = et;
          end else begin
            m_hold     = 1'b1;
            m_hold_bus = mk_ds(bdd, pc, 32'h0, ex, et);
          end
        end
      end
      tick();
      check_cnt++;
      if (fs_to_ds_valid !== m_hold)
        $display("[TB] FAIL rand_valid@%0d: got %0b, want %0b", cyc, fs_to_ds_valid, m_hold);
      else pass_cnt++;
      if (m_hold) begin
        check_cnt++;
        if (fs_to_ds_bus !== m_hold_bus)
          $display("[TB] FAIL rand_bus@%0d: got %h, want %h", cyc, fs_to_ds_bus, m_hold_bus);
        else pass_cnt++;
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    test_reset();
    test_basic_fetch();
    test_exception_and_stall();
    test_flush_drop();
    test_flush_with_data_ok();
    test_flush_priority();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
